spi_txn_scheduler: RTL and testbench

Sequencer and arbiter that shares the single SPI master among three requesters, one per slave select (slave 1/2/3).
- Grants one requester at a time, round-robin.
- Programs the master's data, mode and slave-select inputs, pulses its load and start inputs, and waits for the select lines to go active and then release.
- Returns the received byte and a completion/error pulse to the granted requester.
- Sits between the system-side requesters and the SPI master; the master's clock generation is untouched.

---
 rtl/spi_txn_scheduler.sv | 194 +++++++++++++++++++
 tb/tb_spi_txn_scheduler.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_txn_scheduler.sv
// Round-robin scheduler that shares one SPI master among three requesters.
// Each grant programs the master, starts it, tracks its selects and returns the result.
module spi_txn_scheduler #(
    parameter int SETUP_CYC = 2,
    parameter int GAP_CYC   = 4,
    parameter int TO_CYC    = 1023,
    parameter int CNT_W     = 10
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [2:0]  REQ,
    input  logic [23:0] TX_DATA,
    input  logic [5:0]  MODE,
    output logic [2:0]  GNT,
    output logic [2:0]  DONE,
    output logic [7:0]  RX_DATA,
    output logic        ERR,
    output logic        BUSY,
    output logic [7:0]  M_DATA,
    output logic        M_READ_MEMORY,
    output logic        M_START,
    output logic        M_CPOL,
    output logic        M_CPHA,
    output logic [2:0]  M_SS,
    input  logic [2:0]  M_SS_OUT,
    input  logic [7:0]  M_RX,
    input  logic        M_VALID_SEL
);
    typedef enum logic [2:0] {
        IDLE, LOAD, SETUP, START, WAIT_SEL, WAIT_DONE, COMPLETE, GAP
    } state_t;

    localparam logic [CNT_W-1:0] SETUP_LIM = CNT_W'(SETUP_CYC);
    localparam logic [CNT_W-1:0] GAP_LIM   = CNT_W'(GAP_CYC);
    localparam logic [CNT_W-1:0] TO_LIM    = CNT_W'(TO_CYC);

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [1:0]       last_reg;
    logic [2:0]       gnt_reg;
    logic [2:0]       done_reg;
    logic             err_reg;
    logic [7:0]       rx_reg;
    logic             busy_reg;
    logic [7:0]       m_data_reg;
    logic             m_rdmem_reg;
    logic             m_start_reg;
    logic             m_cpol_reg;
    logic             m_cpha_reg;
    logic [2:0]       m_ss_reg;

    logic [7:0] tx_byte   [3];
    logic [1:0] mode_pair [3];

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_unpack
            assign tx_byte[gi]   = TX_DATA[8*gi +: 8];
            assign mode_pair[gi] = MODE[2*gi +: 2];
        end
    endgenerate

    function automatic logic [1:0] rr_index(input logic [1:0] base, input int off);
        int sum;
        sum = (int'(base) + off) % 3;
        return 2'(sum);
    endfunction

    // First requester found after the last winner takes the grant.
    logic       win_found;
    logic [1:0] win_idx;
    always_comb begin
        win_found = 1'b0;
        win_idx   = 2'd0;
        for (int off = 1; off <= 3; off++) begin
            if (!win_found && REQ[rr_index(last_reg, off)]) begin
                win_found = 1'b1;
                win_idx   = rr_index(last_reg, off);
            end
        end
    end

    // Saturating increment so a stuck phase can never wrap the counter.
    logic [CNT_W-1:0] cnt_inc;
    assign cnt_inc = (cnt_reg == '1) ? cnt_reg : cnt_reg + CNT_W'(1);

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            last_reg    <= 2'd2;
            gnt_reg     <= '0;
            done_reg    <= '0;
            err_reg     <= 1'b0;
            rx_reg      <= '0;
            busy_reg    <= 1'b0;
            m_data_reg  <= '0;
            m_rdmem_reg <= 1'b0;
            m_start_reg <= 1'b0;
            m_cpol_reg  <= 1'b0;
            m_cpha_reg  <= 1'b0;
            m_ss_reg    <= 3'b111;
        end else begin
            gnt_reg  <= '0;
            done_reg <= '0;
            case (state_reg)
                IDLE: begin
                    if (win_found) begin
                        gnt_reg                  <= 3'b001 << win_idx;
                        last_reg                 <= win_idx;
                        m_data_reg               <= tx_byte[win_idx];
                        {m_cpol_reg, m_cpha_reg} <= mode_pair[win_idx];
                        m_ss_reg                 <= ~(3'b100 >> win_idx);
                        m_rdmem_reg              <= 1'b1;
                        busy_reg                 <= 1'b1;
                        state_reg                <= LOAD;
                    end
                end
                LOAD: begin
                    m_rdmem_reg <= 1'b0;
                    cnt_reg     <= '0;
                    state_reg   <= SETUP;
                end
                SETUP: begin
                    cnt_reg <= cnt_inc;
                    if (cnt_inc >= SETUP_LIM) begin
                        cnt_reg     <= '0;
                        m_start_reg <= 1'b1;
                        state_reg   <= START;
                    end
                end
                START: begin
                    // Counter tracks cycles since START rose, so the timeout lands TO_CYC after it.
                    cnt_reg   <= CNT_W'(1);
                    state_reg <= WAIT_SEL;
                end
                WAIT_SEL: begin
                    cnt_reg <= cnt_inc;
                    if (M_SS_OUT == m_ss_reg) begin
                        m_start_reg <= 1'b0;
                        cnt_reg     <= '0;
                        state_reg   <= WAIT_DONE;
                    end else if (!M_VALID_SEL || cnt_inc >= TO_LIM) begin
                        m_start_reg <= 1'b0;
                        done_reg    <= 3'b001 << last_reg;
                        err_reg     <= 1'b1;
                        rx_reg      <= '0;
                        state_reg   <= COMPLETE;
                    end
                end
                WAIT_DONE: begin
                    cnt_reg <= cnt_inc;
                    if (M_SS_OUT == 3'b111) begin
                        done_reg  <= 3'b001 << last_reg;
                        err_reg   <= 1'b0;
                        rx_reg    <= M_RX;
                        state_reg <= COMPLETE;
                    end else if (cnt_inc >= TO_LIM) begin
                        done_reg  <= 3'b001 << last_reg;
                        err_reg   <= 1'b1;
                        rx_reg    <= '0;
                        state_reg <= COMPLETE;
                    end
                end
                COMPLETE: begin
                    m_ss_reg  <= 3'b111;
                    cnt_reg   <= '0;
                    state_reg <= GAP;
                end
                GAP: begin
                    cnt_reg <= cnt_inc;
                    if (cnt_inc >= GAP_LIM) begin
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign GNT           = gnt_reg;
    assign DONE          = done_reg;
    assign RX_DATA       = rx_reg;
    assign ERR           = err_reg;
    assign BUSY          = busy_reg;
    assign M_DATA        = m_data_reg;
    assign M_READ_MEMORY = m_rdmem_reg;
    assign M_START       = m_start_reg;
    assign M_CPOL        = m_cpol_reg;
    assign M_CPHA        = m_cpha_reg;
    assign M_SS          = m_ss_reg;
endmodule

// File: tb/tb_spi_txn_scheduler.sv
// Directed bench for spi_txn_scheduler with a small behavioural SPI master model.
module tb_spi_txn_scheduler;
    localparam int GAP_CYC = 4;
    localparam int TO_CYC  = 1023;

    logic        CLK;
    logic        RST_N;
    logic [2:0]  REQ;
    logic [23:0] TX_DATA;
    logic [5:0]  MODE;
    logic [2:0]  GNT;
    logic [2:0]  DONE;
    logic [7:0]  RX_DATA;
    logic        ERR;
    logic        BUSY;
    logic [7:0]  M_DATA;
    logic        M_READ_MEMORY;
    logic        M_START;
    logic        M_CPOL;
    logic        M_CPHA;
    logic [2:0]  M_SS;
    logic [2:0]  M_SS_OUT;
    logic [7:0]  M_RX;
    logic        M_VALID_SEL;

    int checks = 0;
    int errors = 0;

    spi_txn_scheduler dut (
        .CLK(CLK), .RST_N(RST_N), .REQ(REQ), .TX_DATA(TX_DATA), .MODE(MODE),
        .GNT(GNT), .DONE(DONE), .RX_DATA(RX_DATA), .ERR(ERR), .BUSY(BUSY),
        .M_DATA(M_DATA), .M_READ_MEMORY(M_READ_MEMORY), .M_START(M_START),
        .M_CPOL(M_CPOL), .M_CPHA(M_CPHA), .M_SS(M_SS), .M_SS_OUT(M_SS_OUT),
        .M_RX(M_RX), .M_VALID_SEL(M_VALID_SEL)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Master model: asserts the programmed select some cycles after START, releases it later.
    bit model_en  = 1'b1;
    int sel_delay = 3;
    int hold_cyc  = 8;
    int mcnt;
    bit active;
    always @(posedge CLK) begin
        if (!RST_N) begin
            M_SS_OUT <= 3'b111;
            active   <= 1'b0;
            mcnt     <= 0;
        end else if (!active) begin
            if (M_START && model_en) begin
                active <= 1'b1;
                mcnt   <= 0;
            end
        end else begin
            mcnt <= mcnt + 1;
            if (mcnt == sel_delay) M_SS_OUT <= M_SS;
            if (mcnt == sel_delay + hold_cyc) begin
                M_SS_OUT <= 3'b111;
                active   <= 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_txn(input logic [2:0] req, input logic [2:0] exp_gnt,
                           input logic [2:0] exp_ss, input logic [7:0] exp_data,
                           input logic [1:0] exp_mode, input logic [7:0] exp_rx,
                           input logic exp_err, input bit drop_req, input bit kill_valid,
                           output int gnt_wait, output int lat);
        int n;
        REQ = req;
        gnt_wait = 0;
        while (GNT == 3'b000 && gnt_wait < 100) begin
            @(negedge CLK);
            gnt_wait++;
        end
        check("gnt", GNT, exp_gnt);
        check("ss", M_SS, exp_ss);
        check("data", M_DATA, exp_data);
        check("mode", {M_CPOL, M_CPHA}, exp_mode);
        check("rdmem", M_READ_MEMORY, 1'b1);
        check("busy", BUSY, 1'b1);
        if (drop_req) REQ = 3'b000;
        @(negedge CLK);
        check("rdmem_off", M_READ_MEMORY, 1'b0);
        check("gnt_pulse", GNT, 3'b000);
        n = 0;
        while (!M_START && n < 20) begin
            @(negedge CLK);
            n++;
        end
        if (kill_valid) M_VALID_SEL = 1'b0;
        lat = 0;
        while (DONE == 3'b000 && lat < 2000) begin
            @(negedge CLK);
            lat++;
        end
        M_VALID_SEL = 1'b1;
        check("done", DONE, exp_gnt);
        check("rx", RX_DATA, exp_rx);
        check("err", ERR, exp_err);
        check("ss_hold", M_SS, exp_ss);
        check("start_off", M_START, 1'b0);
        $display("txn req=%b gnt=%b ss=%b done=%b rx=%02h err=%b start_to_done=%0d",
                 req, exp_gnt, exp_ss, DONE, RX_DATA, ERR, lat);
        @(negedge CLK);
        check("ss_release", M_SS, 3'b111);
        check("done_pulse", DONE, 3'b000);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, lat, n, dcount;
        RST_N = 1'b0; REQ = '0; TX_DATA = '0; MODE = '0; M_RX = '0; M_VALID_SEL = 1'b1;
        repeat (3) @(negedge CLK);
        check("rst_gnt", GNT, 3'b000);
        check("rst_done", DONE, 3'b000);
        check("rst_busy", BUSY, 1'b0);
        check("rst_ss", M_SS, 3'b111);
        check("rst_misc", {ERR, RX_DATA, M_DATA, M_READ_MEMORY, M_START, M_CPOL, M_CPHA}, '0);
        RST_N = 1'b1;
        @(negedge CLK);

        // Single request
        TX_DATA = 24'hC33CA5; MODE = 6'b10_01_00; M_RX = 8'h55;
        run_txn(3'b001, 3'b001, 3'b011, 8'hA5, 2'b00, 8'h55, 1'b0, 1'b1, 1'b0, w, lat);
        check("gnt_latency", w, 1);

        // Modes and slaves
        M_RX = 8'h33;
        run_txn(3'b010, 3'b010, 3'b101, 8'h3C, 2'b01, 8'h33, 1'b0, 1'b1, 1'b0, w, lat);
        M_RX = 8'h6D;
        run_txn(3'b100, 3'b100, 3'b110, 8'hC3, 2'b10, 8'h6D, 1'b0, 1'b1, 1'b0, w, lat);

        // Timeout: select never asserted
        model_en = 1'b0; M_RX = 8'h99;
        run_txn(3'b001, 3'b001, 3'b011, 8'hA5, 2'b00, 8'h00, 1'b1, 1'b1, 1'b0, w, lat);
        check("to_cycles", lat, TO_CYC);

        // Invalid selection during WAIT_SEL
        run_txn(3'b100, 3'b100, 3'b110, 8'hC3, 2'b10, 8'h00, 1'b1, 1'b1, 1'b1, w, lat);
        check("inv_cycles", lat, 2);
        model_en = 1'b1;

        // Round-robin with all three requesting
        M_RX = 8'h5A;
        run_txn(3'b111, 3'b001, 3'b011, 8'hA5, 2'b00, 8'h5A, 1'b0, 1'b0, 1'b0, w, lat);
        check("rr_gap0", w >= GAP_CYC, 1'b1);
        run_txn(3'b111, 3'b010, 3'b101, 8'h3C, 2'b01, 8'h5A, 1'b0, 1'b0, 1'b0, w, lat);
        check("rr_gap1", w >= GAP_CYC, 1'b1);
        run_txn(3'b111, 3'b100, 3'b110, 8'hC3, 2'b10, 8'h5A, 1'b0, 1'b0, 1'b0, w, lat);
        check("rr_gap2", w >= GAP_CYC, 1'b1);
        run_txn(3'b111, 3'b001, 3'b011, 8'hA5, 2'b00, 8'h5A, 1'b0, 1'b0, 1'b0, w, lat);
        check("rr_gap3", w >= GAP_CYC, 1'b1);
        REQ = 3'b000;

        // Reset during WAIT_DONE
        hold_cyc = 40; M_RX = 8'h77; REQ = 3'b010;
        n = 0;
        while (GNT == 3'b000 && n < 100) begin
            @(negedge CLK);
            n++;
        end
        check("mid_gnt", GNT, 3'b010);
        REQ = 3'b000;
        n = 0;
        while (M_SS_OUT == 3'b111 && n < 100) begin
            @(negedge CLK);
            n++;
        end
        repeat (2) @(negedge CLK);
        check("mid_busy", BUSY, 1'b1);
        RST_N = 1'b0;
        @(negedge CLK);
        check("mid_rst_ss", M_SS, 3'b111);
        check("mid_rst_busy", BUSY, 1'b0);
        check("mid_rst_done", DONE, 3'b000);
        check("mid_rst_misc", {GNT, ERR, RX_DATA, M_DATA, M_READ_MEMORY, M_START, M_CPOL, M_CPHA}, '0);
        $display("txn reset mid-transfer ss=%b busy=%b rx=%02h", M_SS, BUSY, RX_DATA);
        RST_N = 1'b1; hold_cyc = 8;
        dcount = 0;
        repeat (10) begin
            @(negedge CLK);
            if (DONE != 3'b000) dcount++;
        end
        check("mid_no_done", dcount, 0);
        run_txn(3'b010, 3'b010, 3'b101, 8'h3C, 2'b01, 8'h77, 1'b0, 1'b1, 1'b0, w, lat);
        check("post_rst_latency", w, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
